// File: rtl/cbd_bernoulli_sampler_pipe.sv
// Multi-lane Bernoulli-threshold / centered-binomial sampler emitting one polynomial per start.
// Input beat to output beat takes two cycles at one beat per cycle; out_ready low stalls both stages.
module cbd_bernoulli_sampler_pipe #(
  parameter int LANES      = 4,
  parameter int COMP_WIDTH = 8,
  parameter int COEF_WIDTH = 4,
  parameter int POLY_N     = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_i,
  input  logic                          mode_i,
  input  logic [1:0]                    eta_i,
  input  logic [COMP_WIDTH-1:0]         threshold_i,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*COMP_WIDTH-1:0]   in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES-1:0]              out_sign,
  output logic [LANES*COEF_WIDTH-1:0]   out_coef,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done
);
  localparam int BEATS = POLY_N / LANES;
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nxt;

  logic                        mode_q;
  logic [1:0]                  eta_q;
  logic [COMP_WIDTH-1:0]       thr_q;
  logic [CNT_W-1:0]            in_cnt, out_cnt;
  logic                        s1_valid;
  logic [LANES*COMP_WIDTH-1:0] s1_data;
  logic                        s1_load, s2_load, in_fire, out_fire_last;
  logic [LANES-1:0]            calc_sign;
  logic [LANES*COEF_WIDTH-1:0] calc_coef;

  // Only r[5:0] feed the binomial path; the threshold compare is done by the caller.
  function automatic logic [COEF_WIDTH:0] sample(input logic [5:0] r, input logic md,
                                                 input logic eta3, input logic lt);
    logic [1:0] a, b;
    logic s;
    logic [COEF_WIDTH-1:0] c;
    a = 2'(r[0]) + 2'(r[1]) + (eta3 ? 2'(r[2]) : 2'd0);
    b = eta3 ? (2'(r[3]) + 2'(r[4]) + 2'(r[5])) : (2'(r[2]) + 2'(r[3]));
    if (md) begin
      s = (a >= b);
      c = COEF_WIDTH'(a) - COEF_WIDTH'(b);
    end else begin
      s = lt;
      c = lt ? COEF_WIDTH'(1) : '1;
    end
    return {s, c};
  endfunction

  assign s2_load       = !out_valid || out_ready;
  assign s1_load       = !s1_valid || s2_load;
  assign in_ready      = (state == RUN) && (in_cnt != BEATS_C) && s1_load;
  assign in_fire       = in_valid && in_ready;
  assign out_fire_last = out_valid && out_ready && out_last;
  assign busy          = (state != IDLE);

  always_comb begin
    calc_sign = '0;
    calc_coef = '0;
    for (int l = 0; l < LANES; l++) begin
      {calc_sign[l], calc_coef[l*COEF_WIDTH +: COEF_WIDTH]} =
        sample(s1_data[l*COMP_WIDTH +: 6], mode_q, (eta_q != 2'd2),
               (s1_data[l*COMP_WIDTH +: COMP_WIDTH] < thr_q));
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = RUN;
      RUN:     if (in_fire && in_cnt == LAST_C) state_nxt = DRAIN;
      DRAIN:   if (out_fire_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mode_q  <= 1'b0;
      eta_q   <= 2'd0;
      thr_q   <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
      done    <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == DRAIN) && out_fire_last;
      if (state == IDLE && start_i) begin
        mode_q  <= mode_i;
        eta_q   <= eta_i;
        thr_q   <= threshold_i;
        in_cnt  <= '0;
        out_cnt <= '0;
      end else begin
        if (in_fire) in_cnt <= in_cnt + CNT_W'(1);
        if (s2_load && s1_valid) out_cnt <= out_cnt + CNT_W'(1);
      end
    end
  end

  // out_cnt counts beats entering S2, so it tags the final beat as it is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      out_valid <= 1'b0;
      out_sign  <= '0;
      out_coef  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid <= in_fire;
        if (in_fire) s1_data <= in_data;
      end
      if (s2_load) begin
        out_valid <= s1_valid;
        out_last  <= s1_valid && (out_cnt == LAST_C);
        if (s1_valid) begin
          out_sign <= calc_sign;
          out_coef <= calc_coef;
        end
      end
    end
  end
endmodule
